// File: rtl/simple_clk_pkg.sv
// Shared types and constants for the SIMPLE CPU phase sequencer.
//   seq_state_t : sequencer mode (stopped, free-run, single-step)
//   SEG_*       : seven-segment codes shown on the front-panel status LEDs
//   seg_code()  : maps a sequencer mode to its status LED pattern
package simple_clk_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_RUN,
        ST_STEP
    } seq_state_t;

    localparam logic [7:0] SEG_RUN  = 8'b10011110;
    localparam logic [7:0] SEG_STOP = 8'b10110110;
    localparam logic [7:0] SEG_STEP = 8'b11001110;

    function automatic logic [7:0] seg_code(input seq_state_t st);
        logic [7:0] code;
        unique case (st)
            ST_RUN:  code = SEG_RUN;
            ST_STEP: code = SEG_STEP;
            default: code = SEG_STOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/chatter_filter.sv
// Push-button conditioner: two-flop synchroniser, stable-low counter and press pulse.
//   clock  in  system clock
//   reset  in  synchronous active-high reset
//   btn_n  in  raw active-low button, asynchronous to clock
//   press  out one-tick pulse once the button has been low for DEBOUNCE_CYCLES ticks
// A held button produces exactly one pulse; release is accepted immediately.
module chatter_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Saturation value: press already issued for this hold.
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            press   <= 1'b0;
            if (sync2_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q <= CNT_DONE;
                press <= 1'b1;
            end else if (cnt_q != CNT_DONE) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase instruction-cycle sequencer for the SIMPLE CPU datapath.
//   clock        in   system clock
//   reset        in   synchronous active-high reset
//   run_btn      in   raw run/stop button, active-low
//   step_btn     in   raw single-step button, active-low
//   halt         in   CPU halt request (level)
//   phase        out  one-tick phase strobes, phase[k] at counter == k*PHASE_GAP
//   counterout   out  tick counter within the instruction cycle
//   running      out  high in RUN or STEP
//   cycle_count  out  completed instruction cycles (wrapping)
//   statusled    out  seven-segment code of the current mode
//   phaseled     out  one-hot counter/PHASE_GAP
// All outputs are registered from next-state values so they line up with counterout.
module phase_sequencer
    import simple_clk_pkg::*;
#(
    parameter int unsigned NUM_PHASES      = 5,
    parameter int unsigned PHASE_GAP       = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CYC_W           = 16,
    localparam int unsigned CYC_LEN        = NUM_PHASES * PHASE_GAP,
    localparam int unsigned CW             = (CYC_LEN > 1) ? $clog2(CYC_LEN) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run_btn,
    input  logic                  step_btn,
    input  logic                  halt,
    output logic [NUM_PHASES-1:0] phase,
    output logic [CW-1:0]         counterout,
    output logic                  running,
    output logic [CYC_W-1:0]      cycle_count,
    output logic [7:0]            statusled,
    output logic [NUM_PHASES-1:0] phaseled
);

    localparam logic [CW-1:0] CNT_LAST = CW'(CYC_LEN - 1);

    logic run_press;
    logic step_press;

    chatter_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run_filter (
        .clock(clock),
        .reset(reset),
        .btn_n(run_btn),
        .press(run_press)
    );

    chatter_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_filter (
        .clock(clock),
        .reset(reset),
        .btn_n(step_btn),
        .press(step_press)
    );

    seq_state_t            state_q;
    seq_state_t            state_d;
    logic                  stop_pending_q;
    logic                  stop_pending_d;
    logic [CW-1:0]         counter_d;
    logic [CYC_W-1:0]      cycle_count_d;
    logic                  cycle_end;
    logic [NUM_PHASES-1:0] phase_d;
    logic [NUM_PHASES-1:0] phaseled_d;

    // Next-state logic: cycles always run to completion before a stop takes effect.
    always_comb begin
        state_d        = state_q;
        stop_pending_d = stop_pending_q;
        counter_d      = counterout;
        cycle_count_d  = cycle_count;
        cycle_end      = (state_q != ST_STOPPED) && (counterout == CNT_LAST);

        unique case (state_q)
            ST_STOPPED: begin
                stop_pending_d = 1'b0;
                if (run_press) begin
                    state_d = ST_RUN;
                end else if (step_press) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (cycle_end) begin
                    // A request arriving in the final tick still stops at this boundary.
                    if (stop_pending_q || run_press || halt) begin
                        state_d = ST_STOPPED;
                    end
                    stop_pending_d = 1'b0;
                end else begin
                    stop_pending_d = stop_pending_q || run_press || halt;
                end
            end
            ST_STEP: begin
                if (cycle_end) begin
                    state_d = ST_STOPPED;
                end
            end
            default: begin
                state_d = ST_STOPPED;
            end
        endcase

        if (cycle_end) begin
            counter_d     = '0;
            cycle_count_d = cycle_count + 1'b1;
        end else if (state_q != ST_STOPPED) begin
            counter_d = counterout + 1'b1;
        end
    end

    // Strobe and LED decode from the next counter value, registered below.
    always_comb begin
        phase_d    = '0;
        phaseled_d = '0;
        for (int unsigned k = 0; k < NUM_PHASES; k++) begin
            if (32'(counter_d) / PHASE_GAP == k) begin
                phaseled_d[k] = 1'b1;
            end
            if ((state_d != ST_STOPPED) && (32'(counter_d) == k * PHASE_GAP)) begin
                phase_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_STOPPED;
            stop_pending_q <= 1'b0;
            counterout     <= '0;
            cycle_count    <= '0;
            phase          <= '0;
            running        <= 1'b0;
            statusled      <= SEG_STOP;
            phaseled       <= NUM_PHASES'(1);
        end else begin
            state_q        <= state_d;
            stop_pending_q <= stop_pending_d;
            counterout     <= counter_d;
            cycle_count    <= cycle_count_d;
            phase          <= phase_d;
            running        <= (state_d != ST_STOPPED);
            statusled      <= seg_code(state_d);
            phaseled       <= phaseled_d;
        end
    end

endmodule
